rr_grant_scheduler: RTL and testbench
=====================================

// Module: rr_grant_scheduler
// PURPOSE
// Round-robin scheduler sharing one resource among 8 requesters (snake logic, food
// generator, score/display updaters). Produces a registered one-hot grant plus its
// 3-bit binary index. The index uses the team's one-hot-to-binary convention:
// bit k -> k, and 3'd7 when no grant is active. Bounded hold time guarantees fairness.
// PARAMETERS
// N_REQ     8   number of requesters; fixed at 8 because the index is 3 bits
// MAX_HOLD  16  maximum consecutive grant cycles per owner; legal range 2..255
// CNT_W     8   width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
// clk        in   1  system clock, rising edge
// rst_n      in   1  asynchronous active-low reset
// req        in   8  request vector; requester k holds req[k]=1 while it wants the resource
// gnt        out  8  one-hot grant, registered; all zero when idle
// gnt_idx    out  3  binary index of the gnt bit; 3'd7 when idle
// gnt_valid  out  1  1 while any gnt bit is set
// timeout    out  1  one-cycle pulse when a grant is force-revoked at MAX_HOLD
// BEHAVIOUR
// - Reset (rst_n=0, async): gnt=0, gnt_idx=3'd7, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
//   State=IDLE. All of this applies immediately, including in the middle of a grant.
// - States:
//   IDLE:  req==0 -> stay in IDLE.
//          req!=0 -> choose winner w, the first set bit scanning from ptr upward
//          modulo 8. At the next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1,
//          hold_cnt=1, go to GRANT. Latency from req sampled to gnt is 1 cycle.
//   GRANT: evaluated at each edge, in this priority order:
//          (a) req[w]==0 -> gnt=0, gnt_idx=7, gnt_valid=0, ptr=(w+1)%8, go to IDLE.
//          (b) hold_cnt==MAX_HOLD -> same as (a), and timeout=1 for one cycle.
//          (c) otherwise -> hold_cnt++, grant unchanged.
// - An owner therefore holds gnt for at most MAX_HOLD cycles.
// - There is always at least one IDLE cycle (gnt=0) between two grants. No
//   back-to-back grant handoff.
// - Requests from non-owners during GRANT are ignored. They are evaluated in IDLE only.
// - If req[w] drops in the same cycle hold_cnt reaches MAX_HOLD, rule (a) wins:
//   no timeout pulse.
// - A timed-out owner that keeps req high re-competes normally. ptr has already
//   moved past it, so it has the lowest priority.
// - ptr wraps 7 -> 0.
// - gnt is always one-hot or zero. gnt_idx always equals the encoded value of gnt.
// - Any X on req while in IDLE is a bench error. The design does not need to tolerate it.
// TESTING
// 1 Reset then req=8'h00 for 10 cycles -> gnt=0, gnt_idx=7, gnt_valid=0, timeout=0 throughout.
// 2 ptr=0, req=8'b0010_0100 -> 1 cycle later gnt=8'h04, gnt_idx=2. Drop req[2] ->
//   gnt=0 for one cycle, then gnt=8'h20, gnt_idx=5.
// 3 All 8 requesters assert req and each drops it 3 cycles after being granted ->
//   grant order is 0,1,2,...,7,0. Each grant lasts 3 cycles, with one idle cycle between grants.
// 4 MAX_HOLD=16, req=8'h80 held high -> gnt=8'h80 for exactly 16 cycles, timeout
//   pulses once, gnt=0 for 1 cycle, then gnt=8'h80 again.
// 5 Owner w=3 with hold_cnt==MAX_HOLD, and req[3] drops in that same cycle ->
//   gnt clears, timeout stays 0, ptr=4.
// 6 rst_n pulled low asynchronously mid-grant (gnt=8'h10) -> all outputs return
//   to reset values with no clock edge. After release with req=8'h10, gnt=8'h10
//   one cycle later (ptr=0 scan).

Source files
------------

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter over 8 requesters with a bounded hold time and a registered one-hot grant.
// Latency: req to gnt is 1 cycle; each release forces one idle cycle; non-owners wait and are ignored until IDLE.
module rr_grant_scheduler #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [2:0]         ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [2:0]         idx_nxt;
    logic               timeout_nxt;
    logic [2:0]         win;
    logic [2:0]         cand;
    logic               win_found;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        win       = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt   = N_REQ'(1) << win;
                    idx_nxt   = win;
                    hold_nxt  = CNT_W'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A dropped request takes priority over the hold limit, so no timeout then.
                if (!req[gnt_idx] || hold_cnt == CNT_W'(MAX_HOLD)) begin
                    timeout_nxt = req[gnt_idx];
                    gnt_nxt     = '0;
                    idx_nxt     = 3'd7;
                    ptr_nxt     = gnt_idx + 3'd1;
                    state_nxt   = IDLE;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= 3'd7;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: cycle model of the arbitration rules plus directed scenarios.
module tb_rr_grant_scheduler;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_grant_scheduler #(.N_REQ(8), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner is -1 when nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 0;

    function automatic int first_from(input int p, input logic [7:0] r);
        int w;
        w = -1;
        for (int i = 0; i < 8; i++)
            if (w < 0 && r[(p + i) % 8]) w = (p + i) % 8;
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                m_owner = first_from(m_ptr, req);
                m_held  = 1;
            end else if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        chk("model_gnt", gnt, eg);
        chk("model_idx", gnt_idx, (m_owner < 0) ? 7 : m_owner);
        chk("model_valid", gnt_valid, m_owner >= 0);
        chk("model_timeout", timeout, m_to);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int run [8];
        int order[$];
        logic prev_v;
        int exp_order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        // 1: idle after reset
        do_reset();
        repeat (10) begin
            @(negedge clk);
            chk("t1_idle", {gnt, gnt_idx, gnt_valid, timeout}, {8'h00, 3'd7, 1'b0, 1'b0});
        end

        // 2: two requesters, handoff through an idle cycle
        req = 8'b0010_0100;
        @(negedge clk);
        chk("t2_gnt_a", gnt, 8'h04); chk("t2_idx_a", gnt_idx, 3'd2);
        req = 8'b0010_0000;
        @(negedge clk);
        chk("t2_gap", gnt, 8'h00);
        @(negedge clk);
        chk("t2_gnt_b", gnt, 8'h20); chk("t2_idx_b", gnt_idx, 3'd5);

        // 3: all request, each releases after 3 cycles, order wraps 7 -> 0
        do_reset();
        req = 8'hFF;
        prev_v = 1'b0;
        for (int k = 0; k < 8; k++) run[k] = 0;
        for (int c = 0; c < 60 && order.size() < 9; c++) begin
            @(negedge clk);
            if (gnt_valid && !prev_v) order.push_back(int'(gnt_idx));
            for (int k = 0; k < 8; k++) begin
                if (gnt[k]) begin
                    run[k]++;
                    if (run[k] == 3) req[k] = 1'b0;
                end else if (!req[k]) begin
                    req[k] = 1'b1;
                    run[k] = 0;
                end
            end
            prev_v = gnt_valid;
        end
        chk("t3_count", order.size(), 9);
        for (int i = 0; i < 9 && i < order.size(); i++) chk("t3_order", order[i], exp_order[i]);

        // 4: single requester held high, forced revoke at MAX_HOLD
        do_reset();
        req = 8'h80;
        @(negedge clk);
        chk("t4_first", gnt, 8'h80);
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt != 8'h80) break;
            cnt++;
        end
        chk("t4_hold_len", cnt, 16);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_gap", gnt, 8'h00);
        @(negedge clk);
        chk("t4_regrant", gnt, 8'h80);
        chk("t4_to_clear", timeout, 1'b0);

        // 5: owner 3 drops exactly when the hold limit is reached
        do_reset();
        req = 8'h08;
        for (int c = 1; c <= 16; c++) @(negedge clk);
        chk("t5_still", gnt, 8'h08);
        req = 8'h00;
        @(negedge clk);
        chk("t5_clear", gnt, 8'h00); chk("t5_no_to", timeout, 1'b0);
        req = 8'h18;
        @(negedge clk);
        chk("t5_ptr4", gnt, 8'h10); chk("t5_idx4", gnt_idx, 3'd4);

        // 6: asynchronous reset mid-grant
        do_reset();
        req = 8'h10;
        repeat (3) @(negedge clk);
        chk("t6_pre", gnt, 8'h10);
        #2 rst_n = 1'b0;
        #1 chk("t6_async", {gnt, gnt_idx, gnt_valid, timeout}, {8'h00, 3'd7, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_after", gnt, 8'h10); chk("t6_idx", gnt_idx, 3'd4);

        req = 8'h00;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
